// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / branch hazard controller.
// Included by hazard_cmp and hazard_ctrl.
package hazard_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam int         LOAD_LAT_MAX = 3;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use register compare between the ID instruction and a load in EX.
// Writes to r0 never create a dependency.
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_rt == id_rs);
    assign rt_hit = id_uses_rt && (ex_rt == id_rt);
    assign hazard = ex_memread && (ex_rt != REG_ZERO)
                 && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, external freeze.
// Define HAZARD_PERF_CNT_EN to build the saturating bubble counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             ext_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int LAT_C = (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX :
                           (LOAD_LAT < 1) ? 1 : LOAD_LAT;
    localparam logic [1:0] REM_INIT = 2'(LAT_C - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] rem;
    logic [1:0] rem_nxt;
    logic       hazard;
    logic       ev_busy;
    logic       ev_flush;
    logic       ev_lstall;
    logic       ev_luse;

    hazard_cmp u_cmp (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .hazard     (hazard)
    );

    // Mutually exclusive events in priority order
    assign ev_busy   = ext_busy;
    assign ev_flush  = !ext_busy && branch_taken;
    assign ev_lstall = !ext_busy && !branch_taken
                    && (state == LSTALL);
    assign ev_luse   = !ext_busy && !branch_taken
                    && (state == RUN) && hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 2'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        unique case (1'b1)
            ev_busy: begin
                state_nxt = state;
                rem_nxt   = rem;
            end
            ev_flush: begin
                state_nxt = RUN;
                rem_nxt   = 2'd0;
            end
            ev_lstall: begin
                if (rem <= 2'd1) begin
                    state_nxt = RUN;
                    rem_nxt   = 2'd0;
                end else begin
                    rem_nxt   = rem - 2'd1;
                end
            end
            ev_luse: begin
                if (LAT_C > 1) begin
                    state_nxt = LSTALL;
                    rem_nxt   = REM_INIT;
                end
            end
            default: begin
                state_nxt = state;
                rem_nxt   = rem;
            end
        endcase
    end

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            unique case (1'b1)
                ev_busy: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    pipe_freeze = 1'b1;
                end
                ev_flush: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                ev_lstall, ev_luse: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end
                default: begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (idex_bubble && !ext_busy && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table on a
// LOAD_LAT=1 instance plus multi-cycle sequences on a LOAD_LAT=3 instance.
module tb_hazard_ctrl;

    localparam int CW = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_uses_rt;
    logic          ex_memread;
    logic [4:0]    ex_rt;
    logic          branch_taken;
    logic          ext_busy;

    logic          pc1, if1, fl1, bu1, fr1;
    logic          pc3, if3, fl3, bu3, fr3;
    logic [CW-1:0] cnt1, cnt3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(CW)) u_l1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .ext_busy     (ext_busy),
        .pc_we        (pc1),
        .ifid_we      (if1),
        .ifid_flush   (fl1),
        .idex_bubble  (bu1),
        .pipe_freeze  (fr1),
        .stall_cnt    (cnt1)
    );

    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(CW)) u_l3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .ext_busy     (ext_busy),
        .pc_we        (pc3),
        .ifid_we      (if3),
        .ifid_flush   (fl3),
        .idex_bubble  (bu3),
        .pipe_freeze  (fr3),
        .stall_cnt    (cnt3)
    );

    // Output bundle order: {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze}
    localparam logic [4:0] O_RUN = 5'b11000;
    localparam logic [4:0] O_STL = 5'b00010;
    localparam logic [4:0] O_FRZ = 5'b00001;
    localparam logic [4:0] O_RST = 5'b00010;
    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] M_BR  = 5'b10111;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic       mrd;
        logic [4:0] xrt;
        logic       br;
        logic       busy;
        logic [4:0] exp;
        logic [4:0] mask;
    } vec_t;

    vec_t vt[13];

    function automatic logic [4:0] o1();
        return {pc1, if1, fl1, bu1, fr1};
    endfunction

    function automatic logic [4:0] o3();
        return {pc3, if3, fl3, bu3, fr3};
    endfunction

    task automatic chk(input string nm, input logic [4:0] act,
                       input logic [4:0] exp, input logic [4:0] msk);
        total++;
        if ((act & msk) !== (exp & msk)) begin
            bad++;
            $display("FAIL %s: got %b want %b (mask %b)", nm, act, exp, msk);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [CW-1:0] act,
                           input int exp);
        total++;
        if (act !== CW'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_rs        = 5'd0;
        id_rt        = 5'd0;
        id_uses_rt   = 1'b0;
        ex_memread   = 1'b0;
        ex_rt        = 5'd0;
        branch_taken = 1'b0;
        ext_busy     = 1'b0;
    endtask

    task automatic set_luse_rt5();
        idle();
        id_rt      = 5'd5;
        id_uses_rt = 1'b1;
        ex_memread = 1'b1;
        ex_rt      = 5'd5;
    endtask

    // Apply reset for a cycle and leave it released at a negedge
    task automatic do_reset(input string nm);
        idle();
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_l1"}, o1(), O_RST, M_ALL);
        chk({nm, "_rst_l3"}, o3(), O_RST, M_ALL);
        chk_cnt({nm, "_rst_cnt"}, cnt3, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Inputs already driven at a negedge: settle, then move to next negedge
    task automatic settle();
        #1;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{"idle",      0,  0, 0, 0,  0, 0, 0, O_RUN, M_ALL};
        vt[1]  = '{"rs_hit",    8,  0, 0, 1,  8, 0, 0, O_STL, M_ALL};
        vt[2]  = '{"rt_hit",    0,  5, 1, 1,  5, 0, 0, O_STL, M_ALL};
        vt[3]  = '{"rt_nouse",  0,  5, 0, 1,  5, 0, 0, O_RUN, M_ALL};
        vt[4]  = '{"no_load",   8,  0, 0, 0,  8, 0, 0, O_RUN, M_ALL};
        vt[5]  = '{"r0_rs",     0,  0, 0, 1,  0, 0, 0, O_RUN, M_ALL};
        vt[6]  = '{"r0_rt",     3,  0, 1, 1,  0, 0, 0, O_RUN, M_ALL};
        vt[7]  = '{"miss",      9,  7, 1, 1,  8, 0, 0, O_RUN, M_ALL};
        vt[8]  = '{"br",        0,  0, 0, 0,  0, 1, 0, 5'b10110, M_BR};
        vt[9]  = '{"br_haz",    8,  0, 0, 1,  8, 1, 0, 5'b10110, M_BR};
        vt[10] = '{"busy_all",  8,  0, 0, 1,  8, 1, 1, O_FRZ, M_ALL};
        vt[11] = '{"busy",      0,  0, 0, 0,  0, 0, 1, O_FRZ, M_ALL};
        vt[12] = '{"r31",      31,  0, 0, 1, 31, 0, 0, O_STL, M_ALL};

        idle();
        rst_n = 1'b1;
        @(negedge clk);
        do_reset("init");

        foreach (vt[i]) begin
            id_rs        = vt[i].rs;
            id_rt        = vt[i].rt;
            id_uses_rt   = vt[i].uses;
            ex_memread   = vt[i].mrd;
            ex_rt        = vt[i].xrt;
            branch_taken = vt[i].br;
            ext_busy     = vt[i].busy;
            settle();
            chk({"vec_", vt[i].name}, o1(), vt[i].exp, vt[i].mask);
            next();
        end

        // Single-cycle load-use stall with LOAD_LAT=1
        do_reset("l1");
        idle();
        id_rs = 5'd8; ex_memread = 1'b1; ex_rt = 5'd8;
        settle();
        chk("l1_stall", o1(), O_STL, M_ALL);
        next();
        idle();
        settle();
        chk("l1_run", o1(), O_RUN, M_ALL);
        chk_cnt("l1_cnt", cnt1, CNT_ON);
        next();

        // Three bubbles with LOAD_LAT=3 on an rt dependency
        do_reset("l3");
        set_luse_rt5();
        settle();
        chk("l3_b1", o3(), O_STL, M_ALL);
        next();
        idle();
        settle();
        chk("l3_b2", o3(), O_STL, M_ALL);
        next();
        settle();
        chk("l3_b3", o3(), O_STL, M_ALL);
        next();
        settle();
        chk("l3_run", o3(), O_RUN, M_ALL);
        chk_cnt("l3_cnt", cnt3, 3 * CNT_ON);
        set_luse_rt5();
        id_uses_rt = 1'b0;
        settle();
        chk("l3_nouse_a", o3(), O_RUN, M_ALL);
        next();
        settle();
        chk("l3_nouse_b", o3(), O_RUN, M_ALL);
        next();

        // Load into r0 never stalls
        do_reset("r0");
        idle();
        ex_memread = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("r0_l1_c%0d", c), o1(), O_RUN, M_ALL);
            chk($sformatf("r0_l3_c%0d", c), o3(), O_RUN, M_ALL);
            next();
        end

        // Branch resolves during the second LSTALL cycle
        do_reset("br");
        set_luse_rt5();
        settle();
        chk("br_b1", o3(), O_STL, M_ALL);
        next();
        idle();
        settle();
        chk("br_b2", o3(), O_STL, M_ALL);
        next();
        branch_taken = 1'b1;
        settle();
        chk("br_flush", o3(), 5'b10110, M_BR);
        next();
        idle();
        settle();
        chk("br_run1", o3(), O_RUN, M_ALL);
        next();
        settle();
        chk("br_run2", o3(), O_RUN, M_ALL);
        chk_cnt("br_cnt", cnt3, 3 * CNT_ON);
        next();

        // External busy while one stall cycle remains
        do_reset("bz");
        set_luse_rt5();
        settle();
        chk("bz_b1", o3(), O_STL, M_ALL);
        next();
        idle();
        settle();
        chk("bz_b2", o3(), O_STL, M_ALL);
        next();
        ext_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("bz_frz%0d", c), o3(), O_FRZ, M_ALL);
            chk_cnt($sformatf("bz_cnt%0d", c), cnt3, 2 * CNT_ON);
            next();
        end
        ext_busy = 1'b0;
        settle();
        chk("bz_b3", o3(), O_STL, M_ALL);
        next();
        settle();
        chk("bz_run", o3(), O_RUN, M_ALL);
        chk_cnt("bz_cnt", cnt3, 3 * CNT_ON);
        next();

        // Asynchronous reset in the middle of LSTALL
        do_reset("ar");
        set_luse_rt5();
        settle();
        chk("ar_b1", o3(), O_STL, M_ALL);
        next();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_async", o3(), O_RST, M_ALL);
        chk_cnt("ar_cnt", cnt3, 0);
        next();
        rst_n = 1'b1;
        settle();
        chk("ar_run1", o3(), O_RUN, M_ALL);
        next();
        settle();
        chk("ar_run2", o3(), O_RUN, M_ALL);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_LAT, default 1, load-use stall length in cycles, legal range 1..3.
REQ-002 Parameter CNT_W, default 32, width of stall_cnt.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs  in  5  rs field of the instruction in ID.
REQ-006 id_rt  in  5  rt field of the instruction in ID.
REQ-007 id_uses_rt  in  1  the ID instruction reads rt (R-type, store, branch).
REQ-008 ex_memread  in  1  the instruction in EX is a load (from ID/EX mem control).
REQ-009 ex_rt  in  5  load destination register (ID/EX instr20_16).
REQ-010 branch_taken  in  1  a taken branch or jump has resolved in EX/MEM.
REQ-011 ext_busy  in  1  the memory side cannot accept progress this cycle.
REQ-012 pc_we  out  1  PC write enable.
REQ-013 ifid_we  out  1  IF/ID write enable.
REQ-014 ifid_flush  out  1  clear IF/ID to NOP.
REQ-015 idex_bubble  out  1  load zero control (wb/mem/ex) into ID/EX.
REQ-016 pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-017 stall_cnt  out  CNT_W  saturating count of bubble cycles.

Function
REQ-018 The block SHALL hold states RUN and LSTALL plus a 2-bit down-counter rem; outputs SHALL be combinational from state, rem and inputs.
REQ-019 The block SHALL detect a load-use hazard when ex_memread=1, ex_rt!=0, and either ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
REQ-020 The block SHALL apply this priority: ext_busy, then branch_taken, then the load-use hazard or LSTALL.
REQ-021 When ext_busy=1, the block SHALL drive pc_we=0, ifid_we=0, pipe_freeze=1, idex_bubble=0 and ifid_flush=0, and SHALL hold state, rem and stall_cnt unchanged.
REQ-022 When branch_taken=1 and ext_busy=0, the block SHALL drive pc_we=1, ifid_flush=1 and idex_bubble=1, and SHALL enter RUN with rem=0 in any state.
REQ-023 In RUN, when a hazard is detected and there is no higher-priority event, the block SHALL drive pc_we=0, ifid_we=0 and idex_bubble=1 in that cycle.
REQ-024 On a detected hazard with LOAD_LAT>1, the block SHALL enter LSTALL next cycle with rem=LOAD_LAT-1; with LOAD_LAT=1 it SHALL stay in RUN.
REQ-025 In LSTALL, with no higher-priority event, the block SHALL drive pc_we=0, ifid_we=0 and idex_bubble=1 and decrement rem; it SHALL return to RUN when rem reaches 0.
REQ-026 In LSTALL, the block SHALL NOT re-evaluate hazard detection.
REQ-027 In RUN with no event, the block SHALL drive pc_we=1, ifid_we=1 and all other controls 0.
REQ-028 A hazard that involves register 0 SHALL NOT stall.

Reset
REQ-029 While rst_n=0, the block SHALL force state=RUN, rem=0, stall_cnt=0, pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1 and pipe_freeze=0.
REQ-030 Reset asserted mid-LSTALL SHALL abandon the stall immediately.
REQ-031 The first edge after rst_n rises SHALL see RUN behaviour.

Configuration
REQ-032 With HAZARD_PERF_CNT_EN defined, stall_cnt SHALL increment on each cycle with idex_bubble=1 and ext_busy=0, saturating at all-ones.
REQ-033 Without HAZARD_PERF_CNT_EN, stall_cnt SHALL be the constant 0 and no counter flops SHALL exist; the port list is unchanged.

Structure
REQ-034 Shared package hazard_pkg SHALL hold the state enum (RUN, LSTALL), the REG_ZERO constant (5'd0) and the LOAD_LAT maximum (3).
REQ-035 The register-compare logic SHALL be one combinational sub-module, hazard_cmp, with inputs id_rs, id_rt, id_uses_rt, ex_memread and ex_rt, and output hazard.
REQ-036 No other sub-modules SHALL exist.

Verification
REQ-037 LOAD_LAT=1; ex_memread=1, ex_rt=8, id_rs=8 for one cycle -> pc_we=0, ifid_we=0 and idex_bubble=1 for exactly 1 cycle, then RUN; stall_cnt=1.
REQ-038 LOAD_LAT=3; hazard on id_rt=5 with id_uses_rt=1 -> 3 consecutive bubble cycles, then pc_we=1; id_uses_rt=0 with the same fields -> no stall.
REQ-039 ex_rt=0, id_rs=0, ex_memread=1 -> no stall; pc_we=1 and ifid_we=1 every cycle.
REQ-040 LOAD_LAT=3; branch_taken=1 in the 2nd LSTALL cycle -> ifid_flush=1, idex_bubble=1 and pc_we=1 that cycle; RUN next cycle; no further bubbles.
REQ-041 ext_busy=1 for 4 cycles during LSTALL with rem=1 -> pipe_freeze=1 and stall_cnt held for 4 cycles; one more bubble after release, then RUN.
REQ-042 rst_n pulsed low mid-LSTALL -> outputs take reset values asynchronously; stall_cnt=0; RUN after release.
